// File: rtl/adbg_wb_slave_mem.sv
// adbg_wb_slave_mem: Wishbone classic-cycle responder backed by a word-organised
// RAM with byte-lane writes and a programmable number of wait states.
// A request is latched in IDLE. The FSM then counts WAIT_STATES idle cycles and
// answers with a one-cycle ack (or err) pulse in RESP.
// Optional macro ADBG_WB_SLAVE_ERR_EN enables the address-window decode. When
// it is set, out-of-window or sel=0 accesses are answered with wb_err_o.
module adbg_wb_slave_mem #(
    parameter int          ADDR_WIDTH  = 8,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          WAIT_STATES = 2
) (
    input  logic        wb_clk_i,
    input  logic        rst_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic [2:0]  wb_cti_i,
    input  logic [1:0]  wb_bte_i,
    input  logic        wb_cab_i,
    output logic        wb_ack_o,
    output logic        wb_err_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t                state_q;
    logic [3:0]            cnt_q;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic                  we_q;
    logic [3:0]            sel_q;
    logic [31:0]           dat_q;
    logic                  bad_q;
    logic                  ack_q;
    logic                  err_q;
    logic [31:0]           rdat_q;

    logic [31:0] mem [2**ADDR_WIDTH];

    logic                  req;
    logic [31:0]           req_off;
    logic [ADDR_WIDTH-1:0] req_idx;
    logic                  req_bad;
    logic                  take_now;
    logic                  finish_wait;
    logic                  enter_resp;
    logic                  c_we;
    logic [3:0]            c_sel;
    logic [31:0]           c_dat;
    logic [ADDR_WIDTH-1:0] c_idx;
    logic                  c_bad;
    logic                  mem_wr;

    assign req     = wb_cyc_i & wb_stb_i;
    assign req_off = wb_adr_i - BASE_ADDR;
    assign req_idx = req_off[ADDR_WIDTH+1:2];

`ifdef ADBG_WB_SLAVE_ERR_EN
    // Window decode: below base, beyond the top of the RAM, or no lanes selected.
    assign req_bad = (wb_adr_i < BASE_ADDR) ||
                     ((req_off >> (ADDR_WIDTH + 2)) != 32'h0) ||
                     (wb_sel_i == 4'b0000);
`else
    assign req_bad = 1'b0;
`endif

    // With zero wait states the response is committed at the sample edge itself.
    // In that case the live bus inputs are used in place of the latched copy.
    assign take_now    = (state_q == ST_IDLE) && req && (WAIT_STATES == 0);
    assign finish_wait = (state_q == ST_WAIT) && wb_cyc_i && (cnt_q == 4'd1);
    assign enter_resp  = take_now | finish_wait;

    assign c_we  = take_now ? wb_we_i  : we_q;
    assign c_sel = take_now ? wb_sel_i : sel_q;
    assign c_dat = take_now ? wb_dat_i : dat_q;
    assign c_idx = take_now ? req_idx  : idx_q;
    assign c_bad = take_now ? req_bad  : bad_q;

    assign mem_wr = enter_resp && c_we && !c_bad;

    // Byte-lane RAM write, committed on the edge that enters RESP.
    always_ff @(posedge wb_clk_i) begin
        if (mem_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (c_sel[i]) begin
                    mem[c_idx][8*i +: 8] <= c_dat[8*i +: 8];
                end
            end
        end
    end

    // Request FSM with registered ack/err/read-data outputs.
    always_ff @(posedge wb_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= 4'b0000;
            dat_q   <= 32'h0;
            bad_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdat_q  <= 32'h0;
        end else begin
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            rdat_q <= 32'h0;
            if (enter_resp) begin
                ack_q  <= !c_bad;
                err_q  <= c_bad;
                rdat_q <= (!c_we && !c_bad) ? mem[c_idx] : 32'h0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        idx_q <= req_idx;
                        we_q  <= wb_we_i;
                        sel_q <= wb_sel_i;
                        dat_q <= wb_dat_i;
                        bad_q <= req_bad;
                        cnt_q <= 4'(WAIT_STATES);
                        state_q <= (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!wb_cyc_i) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= 4'd0;
                    end else if (cnt_q == 4'd1) begin
                        state_q <= ST_RESP;
                        cnt_q   <= 4'd0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;
    assign wb_dat_o = rdat_q;

    // Burst/cycle-type hints and sub-word address bits carry no meaning here.
    logic unused_inputs;
    assign unused_inputs = ^{wb_cti_i, wb_bte_i, wb_cab_i, req_off};

endmodule

// File: tb/tb_adbg_wb_slave_mem.sv
// Testbench for adbg_wb_slave_mem.
// Instance 0 runs with WAIT_STATES=2 and instance 1 with WAIT_STATES=0.
// Expected responses are pushed to a scoreboard queue when a request is driven.
// They are popped and compared when the DUT responds.
module tb_adbg_wb_slave_mem;

    typedef struct packed {
        logic        ack;
        logic        err;
        logic        chk_dat;
        logic [31:0] dat;
        logic [7:0]  lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc  [2];
    logic        stb  [2];
    logic        we   [2];
    logic [31:0] adr  [2];
    logic [31:0] wdat [2];
    logic [3:0]  sel  [2];
    logic [31:0] rdat [2];
    logic        ack  [2];
    logic        err  [2];
    logic [2:0]  tb_cti = 3'b000;
    logic [1:0]  tb_bte = 2'b00;
    logic        tb_cab = 1'b0;

    logic [31:0] model [2][256];
    exp_t        sb_q [$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            adbg_wb_slave_mem #(
                .ADDR_WIDTH (8),
                .BASE_ADDR  (32'h0),
                .WAIT_STATES((gi == 0) ? 2 : 0)
            ) u_dut (
                .wb_clk_i(clk),
                .rst_i   (rst),
                .wb_adr_i(adr[gi]),
                .wb_dat_i(wdat[gi]),
                .wb_dat_o(rdat[gi]),
                .wb_cyc_i(cyc[gi]),
                .wb_stb_i(stb[gi]),
                .wb_sel_i(sel[gi]),
                .wb_we_i (we[gi]),
                .wb_cti_i(tb_cti),
                .wb_bte_i(tb_bte),
                .wb_cab_i(tb_cab),
                .wb_ack_o(ack[gi]),
                .wb_err_o(err[gi])
            );
        end
    endgenerate

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic quiet(input string tag, input int d);
        check(tag, {29'h0, ack[d], err[d], |rdat[d]}, 32'h0);
    endtask

    // One full classic cycle.
    // The caller is at a negedge. The task returns at the negedge after the response cycle.
    task automatic txn(input string tag, input int d, input logic w, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] wd);
        exp_t e;
        int   idx;
        int   n;
        bit   got;
        logic bad;
        idx = int'(a[9:2]);
        bad = 1'b0;
`ifdef ADBG_WB_SLAVE_ERR_EN
        bad = (a >= 32'h400) || (s == 4'b0000);
`endif
        e.ack     = !bad;
        e.err     = bad;
        e.chk_dat = !w || bad;
        e.dat     = (w || bad) ? 32'h0 : model[d][idx];
        e.lat     = (d == 0) ? 8'd3 : 8'd1;
        if (w && !bad) begin
            for (int i = 0; i < 4; i++) begin
                if (s[i]) model[d][idx][8*i +: 8] = wd[8*i +: 8];
            end
        end
        sb_q.push_back(e);
        cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; sel[d] = s; wdat[d] = wd;
        n = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (ack[d] || err[d]) got = 1'b1;
        end
        cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
        e = sb_q.pop_front();
        check({tag, "_seen"}, {31'h0, got}, 32'h1);
        check({tag, "_lat"}, n, {24'h0, e.lat});
        check({tag, "_ack"}, {31'h0, ack[d]}, {31'h0, e.ack});
        check({tag, "_err"}, {31'h0, err[d]}, {31'h0, e.err});
        if (e.chk_dat) check({tag, "_dat"}, rdat[d], e.dat);
        @(negedge clk);
        quiet({tag, "_after"}, d);
        $display("txn %s dut=%0d we=%0b adr=%h sel=%b wdat=%h -> ack=%0b err=%0b dat=%h lat=%0d",
                 tag, d, w, a, s, wd, e.ack, e.err, e.dat, n);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
            adr[d] = 32'h0; wdat[d] = 32'h0; sel[d] = 4'h0;
        end

        // Reset values
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) quiet("reset", d);
        rst = 1'b0;

        // Idle bus: no response for 10 clocks
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            quiet("idle0", 0);
            quiet("idle1", 1);
        end

        // WAIT_STATES=2: full-word write/read, then a single-lane write
        txn("wr10", 0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
        txn("rd10", 0, 1'b0, 32'h10, 4'hF, 32'h0);
        txn("wrlane", 0, 1'b1, 32'h10, 4'b0001, 32'h000000AA);
        txn("rdlane", 0, 1'b0, 32'h10, 4'hF, 32'h0);
        check("lane_val", model[0][4], 32'hDEADBEAA);

        // Abort: cyc dropped during WAIT leaves memory untouched
        txn("wr20", 0, 1'b1, 32'h20, 4'hF, 32'h55AA55AA);
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; adr[0] = 32'h20; sel[0] = 4'hF;
        wdat[0] = 32'h12345678;
        @(negedge clk);
        cyc[0] = 1'b0; stb[0] = 1'b0; we[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            quiet("abort_quiet", 0);
        end
        $display("txn abort dut=0 adr=00000020 -> no response");
        txn("rd20", 0, 1'b0, 32'h20, 4'hF, 32'h0);

        // Reset mid-transaction discards the pending write
        txn("wr30", 0, 1'b1, 32'h30, 4'hF, 32'h11112222);
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; adr[0] = 32'h30; sel[0] = 4'hF;
        wdat[0] = 32'h99999999;
        @(negedge clk);
        rst = 1'b1;
        #1;
        quiet("rst_mid", 0);
        cyc[0] = 1'b0; stb[0] = 1'b0; we[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            quiet("rst_quiet", 0);
        end
        $display("txn rstmid dut=0 adr=00000030 -> no response");
        txn("rd30", 0, 1'b0, 32'h30, 4'hF, 32'h0);

        // WAIT_STATES=0: back-to-back accesses
        txn("wr0", 1, 1'b1, 32'h0, 4'hF, 32'hCAFEF00D);
        txn("wr4", 1, 1'b1, 32'h4, 4'hF, 32'h0BADC0DE);
        txn("rd0", 1, 1'b0, 32'h0, 4'hF, 32'h0);
        txn("rd4", 1, 1'b0, 32'h4, 4'hF, 32'h0);

        // sel=0 write changes nothing (err when the decode is enabled)
        txn("wrsel0", 1, 1'b1, 32'h4, 4'h0, 32'hFFFFFFFF);
        txn("rd4b", 1, 1'b0, 32'h4, 4'hF, 32'h0);

        // Out-of-window access: alias to word 0, or err with the decode enabled
        txn("wr400", 1, 1'b1, 32'h400, 4'hF, 32'h77777777);
        txn("rd0b", 1, 1'b0, 32'h0, 4'hF, 32'h0);
        txn("rd400", 1, 1'b0, 32'h400, 4'hF, 32'h0);
        txn("wr400s", 0, 1'b1, 32'h400, 4'hF, 32'h66666666);
        txn("rd0s", 0, 1'b0, 32'h0, 4'hF, 32'h0);

        check("sb_empty", sb_q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
